clk_div_gated: RTL and testbench

Parametrised, glitch-free programmable clock divider with integrated clock gating, running on a single source clock. It produces a divided clock of any ratio from 1 to 2^DIV_WIDTH-1, with 50% duty cycle for both even and odd ratios. Ratio changes and enable changes are accepted at any time but applied only on a period boundary. It sits between the clock-tree cells and peripheral clock domains, for example UART, SPI or timer functional clocks.

---
 rtl/clk_div_gated.sv | 103 ++++++++++
 tb/tb_clk_div_gated.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gated.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_div_gated : glitch-free programmable divider (1..2^W-1, 50% duty)    |
// | with integrated clock gating and boundary-aligned divisor handshake.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module clk_div_gated #(
  parameter int DIV_WIDTH = 8,
  parameter int DIV_RST   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 te_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 clk_o,
  output logic                 tick_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_RST_V = DIV_WIDTH'(DIV_RST);
  localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO       = DIV_WIDTH'(2);

  state_e               run_q, run_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 pos_q, pos_d;
  logic                 neg_q;
  logic                 gate_en;
  logic [DIV_WIDTH-1:0] n_cur, n_nxt;
  logic                 act, last, accept, apply;
  logic                 bypass;

  always_comb begin
    act        = en_i | te_i;
    n_cur      = (div_q < TWO) ? ONE : div_q;
    last       = (cnt_q == n_cur - ONE);
    accept     = div_valid_i & ~pend_q;
    // pend_q already set means acceptance happened on an earlier edge.
    apply      = pend_q & ((run_q == IDLE) | last);
    div_d      = apply ? pend_div_q : div_q;
    pend_d     = apply ? 1'b0 : (pend_q | accept);
    pend_div_d = accept ? div_i : pend_div_q;

    run_d = run_q;
    case (run_q)
      IDLE:    if (act) run_d = RUN;
      RUN:     if (last && !act) run_d = IDLE;
      default: run_d = IDLE;
    endcase

    cnt_d = '0;
    if (run_q == RUN && run_d == RUN && !last) cnt_d = cnt_q + ONE;

    n_nxt = (div_d < TWO) ? ONE : div_d;
    pos_d = (run_d == RUN) && (cnt_d < (n_nxt >> 1));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q      <= IDLE;
      div_q      <= DIV_RST_V;
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      cnt_q      <= '0;
      pos_q      <= 1'b0;
    end else begin
      run_q      <= run_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
    end
  end

  // Half-cycle extension of the high phase for odd ratios.
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) neg_q <= 1'b0;
    else          neg_q <= pos_q;
  end

  // Bypass gate: transparent while clk_i is low so the AND never chops a pulse.
  always_latch begin
    if (!rst_n_i)    gate_en <= 1'b0;
    else if (!clk_i) gate_en <= (run_d == RUN);
  end

  always_comb begin
    bypass      = (div_q < TWO);
    clk_o       = bypass ? (clk_i & gate_en) : (div_q[0] ? (pos_q | neg_q) : pos_q);
    tick_o      = (run_q == RUN) && (cnt_q == '0);
    div_ready_o = ~pend_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gated.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_clk_div_gated : vector table, directed corner sequences and random    |
// | stimulus against a period-level waveform model.  Revision: 1.0           |
// +--------------------------------------------------------------------------+
module tb_clk_div_gated;

  localparam int DW      = 8;
  localparam int DIV_RST = 1;

  logic          clk_i = 1'b0;
  logic          rst_n_i, en_i, te_i, div_valid_i;
  logic          div_ready_o, clk_o, tick_o;
  logic [DW-1:0] div_i;

  clk_div_gated #(.DIV_WIDTH(DW), .DIV_RST(DIV_RST)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .en_i        (en_i),
    .te_i        (te_i),
    .div_valid_i (div_valid_i),
    .div_ready_o (div_ready_o),
    .div_i       (div_i),
    .clk_o       (clk_o),
    .tick_o      (tick_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: one output period of ratio N spans 2N half-cycles of
  // clk_i, the first N of which are high.
  int m_div, m_pend, m_pend_div, m_left, m_n;

  function automatic int eff(input int d);
    return (d < 2) ? 1 : d;
  endfunction

  task automatic model_reset();
    m_div = DIV_RST; m_pend = 0; m_pend_div = 0; m_left = 0; m_n = 1;
  endtask

  task automatic model_step(input bit act, input bit valid, input int d);
    bit boundary;
    bit acc;
    boundary = (m_left <= 1);
    acc      = valid && (m_pend == 0);
    if (m_pend != 0 && boundary) begin
      m_div  = m_pend_div;
      m_pend = 0;
    end
    if (acc) begin
      m_pend     = 1;
      m_pend_div = d;
    end
    if (boundary) begin
      if (act) begin
        m_n    = eff(m_div);
        m_left = m_n;
      end else begin
        m_left = 0;
      end
    end else begin
      m_left--;
    end
  endtask

  logic obs_hi, obs_lo, obs_tick, obs_rdy;

  // Called half way through the low phase; returns at the same point one cycle on.
  task automatic cycle(input bit en, input bit te, input bit valid, input int d);
    int idx;
    bit run;
    en_i = en; te_i = te; div_valid_i = valid; div_i = DW'(d);
    @(posedge clk_i);
    model_step(en | te, valid, d);
    run = (m_left > 0);
    idx = m_n - m_left;
    #2;
    obs_hi = clk_o; obs_tick = tick_o; obs_rdy = div_ready_o;
    chk("clk_hi", int'(obs_hi), int'(run && (2 * idx < m_n)));
    chk("tick", int'(obs_tick), int'(run && idx == 0));
    chk("ready", int'(obs_rdy), int'(m_pend == 0));
    #5;
    obs_lo = clk_o;
    chk("clk_lo", int'(obs_lo), int'(run && (2 * idx + 1 < m_n)));
  endtask

  task automatic set_div(input int d);
    int g;
    g = 0;
    cycle(1, 0, 1, d);
    while (!obs_rdy && g < 600) begin
      cycle(1, 0, 0, 0);
      g++;
    end
    chk("set_div_done", int'(obs_rdy), 1);
  endtask

  task automatic wait_tick(input bit en, input bit te);
    int g;
    g = 0;
    do begin
      cycle(en, te, 0, 0);
      g++;
    end while (!obs_tick && g < 600);
    chk("wait_tick_done", int'(obs_tick), 1);
  endtask

  task automatic measure_period(input bit en, input bit te, output int per);
    per = 0;
    do begin
      cycle(en, te, 0, 0);
      per++;
    end while (!obs_tick && per < 600);
  endtask

  // Pulse-width monitor on clk_o.
  bit  mon_en = 0;
  bit  mon_armed = 0;
  time t_edge = 0;
  int  last_hi_w = 0;
  int  last_lo_w = 0;

  always @(clk_o) begin
    int w;
    w = int'($time - t_edge);
    if (clk_o === 1'b0) last_hi_w = w;
    else                last_lo_w = w;
    if (mon_en && mon_armed) begin
      n_chk++;
      if (w >= 5) n_pass++;
      else $display("FAIL min_pulse: width %0d ns, required >= 5 ns (t=%0t)", w, $time);
    end
    mon_armed = 1;
    t_edge    = $time;
  end

  typedef struct {
    bit en, te, valid;
    int d;
    bit hi, lo, tick, rdy;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  initial begin
    int per, cnt;
    int sel;

    // en, te, valid, div | clk_hi, clk_lo, tick, ready  (starting from reset, ratio 1)
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 1};
    tbl[1]  = '{1, 0, 0, 0, 1, 0, 1, 1};
    tbl[2]  = '{1, 0, 0, 0, 1, 0, 1, 1};
    tbl[3]  = '{1, 0, 1, 4, 1, 0, 1, 0};
    tbl[4]  = '{1, 0, 0, 0, 1, 1, 1, 1};
    tbl[5]  = '{1, 0, 0, 0, 1, 1, 0, 1};
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 0, 1};
    tbl[7]  = '{1, 0, 0, 0, 0, 0, 0, 1};
    tbl[8]  = '{1, 0, 0, 0, 1, 1, 1, 1};
    tbl[9]  = '{0, 0, 0, 0, 1, 1, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 1};
    tbl[13] = '{0, 1, 0, 0, 1, 1, 1, 1};
    tbl[14] = '{1, 1, 0, 0, 1, 1, 0, 1};
    tbl[15] = '{1, 0, 1, 5, 0, 0, 0, 0};
    tbl[16] = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[17] = '{1, 0, 0, 0, 1, 1, 1, 1};
    tbl[18] = '{1, 0, 0, 0, 1, 1, 0, 1};
    tbl[19] = '{1, 0, 0, 0, 1, 0, 0, 1};
    tbl[20] = '{1, 0, 0, 0, 0, 0, 0, 1};
    tbl[21] = '{1, 0, 0, 0, 0, 0, 0, 1};
    tbl[22] = '{1, 0, 0, 0, 1, 1, 1, 1};

    rst_n_i = 0; en_i = 1; te_i = 0; div_valid_i = 0; div_i = '0;
    model_reset();
    repeat (2) begin
      @(posedge clk_i); #2;
      chk("in_reset_clk_hi", int'(clk_o), 0);
      chk("in_reset_ready", int'(div_ready_o), 1);
      chk("in_reset_tick", int'(tick_o), 0);
      #5;
      chk("in_reset_clk_lo", int'(clk_o), 0);
    end
    rst_n_i = 1;

    for (int i = 0; i < NV; i++) begin
      cycle(tbl[i].en, tbl[i].te, tbl[i].valid, tbl[i].d);
      chk($sformatf("vec%0d_hi", i), int'(obs_hi), int'(tbl[i].hi));
      chk($sformatf("vec%0d_lo", i), int'(obs_lo), int'(tbl[i].lo));
      chk($sformatf("vec%0d_tick", i), int'(obs_tick), int'(tbl[i].tick));
      chk($sformatf("vec%0d_rdy", i), int'(obs_rdy), int'(tbl[i].rdy));
    end
    chk("n5_high_ns", last_hi_w, 25);
    chk("n5_low_ns", last_lo_w, 25);

    // Divisor offered on a boundary edge at N=3; a second offer while busy is dropped.
    set_div(3);
    cnt = 0;
    while (m_left != 1 && cnt < 20) begin
      cycle(1, 0, 0, 0);
      cnt++;
    end
    cycle(1, 0, 1, 6);
    cnt = obs_rdy ? 0 : 1;
    cycle(1, 0, 1, 9);
    if (!obs_rdy) cnt++;
    per = 0;
    while (!obs_rdy && per < 20) begin
      cycle(1, 0, 0, 0);
      if (!obs_rdy) cnt++;
      per++;
    end
    chk("rdy_low_span", cnt, 3);
    chk("apply_on_tick", int'(obs_tick), 1);
    measure_period(1, 0, per);
    chk("period_after_drop", per, 6);

    // Enable loss at cnt=1 with N=8 completes the period, then test enable restarts.
    set_div(8);
    wait_tick(1, 0);
    cycle(1, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0);
      cnt += int'(obs_hi);
    end
    chk("en_drop_high_cycles", cnt, 2);
    chk("idle_clk_lo", int'(obs_lo), 0);
    cycle(0, 1, 0, 0);
    chk("te_restart_tick", int'(obs_tick), 1);
    measure_period(0, 1, per);
    chk("te_period", per, 8);

    // Asynchronous reset in the middle of a high phase at N=7.
    set_div(7);
    wait_tick(1, 0);
    cycle(1, 0, 0, 0);
    chk("pre_reset_high", int'(clk_o), 1);
    rst_n_i = 0;
    #1;
    chk("reset_fall", int'(clk_o), 0);
    chk("reset_ready", int'(div_ready_o), 1);
    chk("reset_tick", int'(tick_o), 0);
    model_reset();
    @(posedge clk_i); #2;
    chk("reset_hold_clk", int'(clk_o), 0);
    @(negedge clk_i); #2;
    rst_n_i = 1;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("post_reset_idle", int'(obs_hi), 0);
    cycle(1, 0, 0, 0);
    chk("post_reset_bypass_hi", int'(obs_hi), 1);
    chk("post_reset_bypass_lo", int'(obs_lo), 0);
    measure_period(1, 0, per);
    chk("post_reset_period", per, 1);

    // Random switching among 0, 2 and 1 under random enables, with pulse monitor.
    mon_armed = 0;
    mon_en    = 1;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 2);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1, (sel == 0) ? 0 : (sel == 1) ? 2 : 1);
    end
    mon_en = 0;

    // Random divisors across a wider range.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) == 0, int'($urandom_range(0, 12)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
